// File: rtl/bank_gen.sv
// Byte-enabled multi-source memory bank with a power-up clear sweep,
// a pipelined read path and selectable read/write collision behaviour.
module bank_gen #(
    parameter int w        = 64,
    parameter int a        = 10,
    parameter int NS       = 3,
    parameter int RL       = 1,
    parameter int WR_FIRST = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [a-1:0]    rd_addr,
    input  logic            wr_en,
    input  logic [a-1:0]    wr_addr,
    input  logic [1:0]      wr_muxcode,
    input  logic [w/8-1:0]  wr_be,
    input  logic [NS*w-1:0] wr_words,
    output logic [w-1:0]    rd_word,
    output logic            rd_valid,
    output logic            init_done,
    output logic            wr_err
);

    localparam int NB = w / 8;
    localparam logic [a-1:0] LAST = '1;

    typedef enum logic {INIT, READY} state_e;

    state_e         state_q;
    logic [a-1:0]   cnt_q;
    logic           last_q;
    logic           init_done_q;
    logic           wr_err_q;

    logic [w-1:0]   mem [0:2**a-1];

    logic [w-1:0]   src;
    logic [w-1:0]   mask;
    logic           src_ok;

    always_comb begin
        src = '0;
        for (int s = 0; s < NS; s++) begin
            if (wr_muxcode == 2'(s)) src = wr_words[s*w +: w];
        end
        for (int k = 0; k < NB; k++) begin
            mask[k*8 +: 8] = {8{wr_be[k]}};
        end
        src_ok = int'(wr_muxcode) < NS;
    end

    logic           ready;
    logic           mem_we;
    logic [a-1:0]   mem_wa;
    logic [w-1:0]   mem_wm;
    logic [w-1:0]   mem_wd;

    assign ready  = (state_q == READY) && !rst;
    assign mem_we = !rst && ((state_q == INIT) || (wr_en && src_ok));
    assign mem_wa = (state_q == INIT) ? cnt_q : wr_addr;
    assign mem_wm = (state_q == INIT) ? '1 : mask;
    assign mem_wd = (state_q == INIT) ? '0 : src;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= (mem[mem_wa] & ~mem_wm) | (mem_wd & mem_wm);
        end
    end

    // last_q delays READY by one cycle after the final sweep address
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            init_done_q <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                INIT: begin
                    cnt_q    <= cnt_q + 1'b1;
                    last_q   <= (cnt_q == LAST);
                    wr_err_q <= 1'b0;
                    if (last_q) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    wr_err_q <= wr_en && !src_ok;
                end
                default: begin
                    state_q     <= INIT;
                    init_done_q <= 1'b0;
                    wr_err_q    <= 1'b0;
                end
            endcase
        end
    end

    logic           rd_fire;
    logic           rd_hit;
    logic [w-1:0]   rd_old;
    logic [w-1:0]   rd_new;

    assign rd_fire = ready && rd_en;
    assign rd_hit  = (WR_FIRST != 0) && wr_en && src_ok
                     && (wr_addr == rd_addr);
    assign rd_old  = mem[rd_addr];
    assign rd_new  = rd_hit ? ((rd_old & ~mask) | (src & mask)) : rd_old;

    logic [RL-1:0]  vld_q;
    logic [w-1:0]   dat_q [RL];

    // data stages only load on valid so the output holds between results
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < RL; k++) dat_q[k] <= '0;
        end else begin
            vld_q[0] <= rd_fire;
            if (rd_fire) dat_q[0] <= rd_new;
            for (int k = 1; k < RL; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) dat_q[k] <= dat_q[k-1];
            end
        end
    end

    assign rd_word   = dat_q[RL-1];
    assign rd_valid  = vld_q[RL-1];
    assign init_done = init_done_q;
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_bank_gen.sv
// Random and directed checks of bank_gen against a queue-based model,
// run on a read-first RL=2 bank and a write-first RL=1 bank side by side.
module tb_bank_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [3:0]   rd_addr;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [1:0]   wr_muxcode;
    logic [7:0]   wr_be;
    logic [191:0] wr_words;

    logic [63:0]  rw0, rw1;
    logic         rv0, rv1, id0, id1, we0, we1;

    always #5 clk = ~clk;

    bank_gen #(.w(64), .a(4), .NS(3), .RL(2), .WR_FIRST(0)) u_rf (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_muxcode(wr_muxcode),
        .wr_be(wr_be), .wr_words(wr_words), .rd_word(rw0),
        .rd_valid(rv0), .init_done(id0), .wr_err(we0)
    );

    bank_gen #(.w(64), .a(4), .NS(3), .RL(1), .WR_FIRST(1)) u_wf (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_muxcode(wr_muxcode),
        .wr_be(wr_be), .wr_words(wr_words), .rd_word(rw1),
        .rd_valid(rv1), .init_done(id1), .wr_err(we1)
    );

    typedef struct {
        int          due;
        logic [63:0] d;
    } rd_t;

    rd_t         q0[$];
    rd_t         q1[$];
    logic [63:0] mm [16];
    logic [63:0] h0, h1;
    int          n = 0;
    int          total = 0;
    int          bad = 0;
    int          nd;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic step();
        logic [255:0] ww;
        logic [63:0]  src, mask, old, nw;
        logic         ok, err_exp, v0, v1;
        ww  = {64'b0, wr_words};
        src = ww[wr_muxcode*64 +: 64];
        for (int k = 0; k < 8; k++) mask[k*8 +: 8] = {8{wr_be[k]}};
        ok  = wr_en && (wr_muxcode < 3);
        old = mm[rd_addr];
        nw  = (ok && wr_addr == rd_addr) ? ((old & ~mask) | (src & mask)) : old;
        if (rd_en) begin
            q0.push_back('{due: n + 2, d: old});
            q1.push_back('{due: n + 1, d: nw});
        end
        if (ok) mm[wr_addr] = (mm[wr_addr] & ~mask) | (src & mask);
        err_exp = wr_en && !(wr_muxcode < 3);
        @(posedge clk);
        #1;
        n++;
        v0 = (q0.size() > 0) && (q0[0].due == n);
        v1 = (q1.size() > 0) && (q1[0].due == n);
        chk("rv_rf", rv0, v0);
        chk("rv_wf", rv1, v1);
        if (v0) begin
            h0 = q0[0].d;
            q0.pop_front();
        end
        if (v1) begin
            h1 = q1[0].d;
            q1.pop_front();
        end
        chk("rw_rf", rw0, h0);
        chk("rw_wf", rw1, h1);
        chk("err", {we0, we1}, {err_exp, err_exp});
        chk("idone", {id0, id1}, 2'b11);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        q0.delete();
        q1.delete();
        h0 = '0;
        h1 = '0;
        @(posedge clk);
        #1;
        chk("rst_rw", {rw0, rw1} == '0, 1'b1);
        chk("rst_rv", {rv0, rv1}, 0);
        chk("rst_id", {id0, id1}, 0);
        chk("rst_err", {we0, we1}, 0);
        rst = 1'b0;
    endtask

    task automatic run_init(input int abort_at, output int done_at);
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            rd_en      = 1'($urandom);
            wr_en      = 1'($urandom);
            rd_addr    = 4'($urandom);
            wr_addr    = 4'($urandom);
            wr_muxcode = 2'($urandom);
            wr_be      = 8'hFF;
            wr_words   = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom};
            @(posedge clk);
            #1;
            chk("init_rv", {rv0, rv1}, 0);
            chk("init_err", {we0, we1}, 0);
            if (id0 && id1) begin
                done_at = c;
                break;
            end
            chk("init_id", {id0, id1}, 0);
            if (c == abort_at) begin
                done_at = -1;
                break;
            end
        end
        idle();
        for (int i = 0; i < 16; i++) mm[i] = '0;
    endtask

    task automatic rd(input logic [3:0] ad);
        idle();
        rd_en   = 1'b1;
        rd_addr = ad;
        step();
    endtask

    task automatic wr(input logic [3:0] ad, input logic [1:0] mx,
                      input logic [7:0] be, input logic [63:0] d);
        idle();
        wr_en      = 1'b1;
        wr_addr    = ad;
        wr_muxcode = mx;
        wr_be      = be;
        wr_words   = '0;
        if (mx < 3) wr_words[mx*64 +: 64] = d;
        step();
    endtask

    initial begin
        rst        = 1'b1;
        rd_addr    = '0;
        wr_addr    = '0;
        wr_muxcode = '0;
        wr_be      = '0;
        wr_words   = '0;
        idle();

        do_reset();
        run_init(0, nd);
        chk("init_lat", nd, 17);

        for (int i = 0; i < 16; i++) rd(4'(i));
        idle();
        repeat (3) step();

        wr(4'd5, 2'd1, 8'hFF, 64'h1122334455667788);
        rd(4'd5);
        idle();
        step();
        chk("src1_rd", rw0, 64'h1122334455667788);

        wr(4'd5, 2'd0, 8'h0F, '1);
        rd(4'd5);
        idle();
        repeat (2) step();
        chk("be_merge", rw0, 64'h11223344FFFFFFFF);

        wr(4'd5, 2'd2, 8'h00, 64'hDEADBEEFDEADBEEF);
        wr(4'd2, 2'd3, 8'hFF, 64'h0123456789ABCDEF);
        idle();
        step();
        rd(4'd2);
        rd(4'd5);
        idle();
        repeat (2) step();

        idle();
        wr_en          = 1'b1;
        wr_addr        = 4'd7;
        wr_muxcode     = 2'd2;
        wr_be          = 8'hFF;
        wr_words       = '0;
        wr_words[128 +: 64] = {16{4'hA}};
        rd_en          = 1'b1;
        rd_addr        = 4'd7;
        step();
        idle();
        repeat (2) step();
        chk("coll_rf", rw0, 64'h0);
        chk("coll_wf", rw1, {16{4'hA}});

        rd(4'd5);
        rd(4'd7);
        rd(4'd2);
        rd(4'd0);
        idle();
        repeat (3) step();

        for (int i = 0; i < 400; i++) begin
            rd_en      = 1'($urandom);
            rd_addr    = 4'($urandom);
            wr_en      = 1'($urandom);
            wr_addr    = 4'($urandom);
            wr_muxcode = 2'($urandom);
            wr_be      = 8'($urandom);
            wr_words   = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom};
            step();
        end
        idle();
        repeat (3) step();

        rd(4'd5);
        do_reset();
        run_init(9, nd);
        chk("abort_at", nd, -1);
        do_reset();
        run_init(0, nd);
        chk("reinit_lat", nd, 17);
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bank_gen.md
BANK_GEN -- requirements
Module: bank_gen

Interface
REQ-001 Parameter w, default 64, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter a, default 10, address width; depth = 2^a words.
REQ-003 Parameter NS, default 3, number of write sources, 1..4.
REQ-004 Parameter RL, default 1, read latency in cycles, 1..3.
REQ-005 Parameter WR_FIRST, default 0; 0 = read-first collision, 1 = write-first collision.
REQ-006 clk  input  1  the only clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 rd_en  input  1  read request.
REQ-009 rd_addr  input  a  read address.
REQ-010 wr_en  input  1  write request.
REQ-011 wr_addr  input  a  write address.
REQ-012 wr_muxcode  input  2  selects the write source index.
REQ-013 wr_be  input  w/8  byte enables; bit k gates byte k.
REQ-014 wr_words  input  NS*w  concatenated source words; source s occupies bits [s*w +: w].
REQ-015 rd_word  output  w  read data.
REQ-016 rd_valid  output  1  rd_word holds data for a request issued RL cycles earlier.
REQ-017 init_done  output  1  memory clear has completed; the bank accepts requests.
REQ-018 wr_err  output  1  one-cycle pulse for an invalid write source.

Function
REQ-019 Two-state FSM, INIT and READY; rst SHALL force INIT with the sweep counter at 0.
REQ-020 INIT: write all-ones byte-enabled zero to counter address each cycle, counter +1; after address 2^a-1, go to READY next cycle.
REQ-021 init_done SHALL be 1 exactly while in READY.
REQ-022 In INIT, rd_en and wr_en SHALL be ignored: no write, no rd_valid, no wr_err.
REQ-023 READY write: wr_en=1 and wr_muxcode<NS SHALL update enabled bytes of mem[wr_addr] with wr_words source wr_muxcode; disabled bytes are unchanged.
REQ-024 READY: wr_en=1 and wr_muxcode>=NS SHALL suppress the write and assert wr_err for the next cycle only.
REQ-025 wr_be all-zero with a valid source SHALL leave memory unchanged and SHALL NOT assert wr_err.
REQ-026 READY read: rd_en at cycle t SHALL produce rd_valid=1 with rd_word=mem[rd_addr] at cycle t+RL, fully pipelined, one result per cycle.
REQ-027 A cycle with rd_valid=0 SHALL hold the previous rd_word.
REQ-028 Same-cycle read and valid write to the same address: WR_FIRST=0 returns the pre-write word; WR_FIRST=1 returns the byte-merged new word.
REQ-029 Reads at cycle t SHALL see every write committed at or before cycle t-1, independent of RL.
REQ-030 Address counters and wr_addr/rd_addr SHALL use natural a-bit width; no wrap logic beyond 2^a-1 -> done.

Reset
REQ-031 On rst: rd_word=0, rd_valid=0 and the read pipeline flushed, init_done=0, wr_err=0, FSM=INIT, counter=0.
REQ-032 rst asserted mid-INIT or mid-read-pipeline SHALL restart the clear from address 0 and discard in-flight reads.
REQ-033 Memory contents SHALL NOT be relied on before init_done; after init_done every word reads 0.

Verification (w=64, a=4, NS=3)
REQ-034 rst 1 cycle, then idle -> init_done rises 17 cycles after rst deasserts; reads of all 16 addresses return 0.
REQ-035 Write source 1 = 0x1122334455667788 to address 5, wr_be=0xFF; read 5 with RL=2 -> rd_valid and that value 2 cycles after rd_en.
REQ-036 Address 5 holds 0x1122334455667788; write source 0 = all-ones with wr_be=0x0F -> read returns 0x11223344FFFFFFFF.
REQ-037 wr_muxcode=3 with wr_en=1 to address 2 -> wr_err pulses 1 cycle; address 2 still reads 0.
REQ-038 Same-cycle read and write of address 7 with 0xAA..AA over 0 -> read returns 0 for WR_FIRST=0 and 0xAA..AA for WR_FIRST=1; back-to-back reads on consecutive cycles give consecutive rd_valid.
REQ-039 rst pulsed at counter=9 in INIT and during an in-flight read -> no rd_valid; init_done rises 17 cycles after rst deasserts.
